dmem_byte_gather: RTL and testbench

- Read-side partner of the byte-serialising data-memory write path.
- Fetches 1, 2 or 4 bytes from the byte-wide data memory, one lane per cycle, lowest lane first.
- Assembles the lanes into a 32-bit load result with sign/zero extension per load type.
- Sits between the byte-wide data memory and the CPU load writeback; the CPU stalls while busy=1.

---
 rtl/dmem_byte_gather_pkg.sv | 31 +++
 rtl/dmem_byte_gather_load_extend.sv | 24 ++
 rtl/dmem_byte_gather.sv | 112 +++++++++++
 tb/tb_dmem_byte_gather.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_byte_gather_pkg.sv
// Shared definitions for the byte-wide data-memory read and write paths:
// load/store type codes, the gather FSM state type, and the lane-count helper.
package dmem_byte_gather_pkg;

  // Load/store type codes, common to the write-side serialiser and the read-side gather.
  localparam logic [2:0] LS_W  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_HU = 3'b010;
  localparam logic [2:0] LS_B  = 3'b011;
  localparam logic [2:0] LS_BU = 3'b100;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANE_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } gather_state_t;

  // Index of the final lane for a load type; unknown codes behave as a full word.
  function automatic logic [1:0] lane_last(input logic [2:0] ls);
    logic [1:0] last;
    case (ls)
      LS_H, LS_HU: last = 2'd1;
      LS_B, LS_BU: last = 2'd0;
      default:     last = 2'd3;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/dmem_byte_gather_load_extend.sv
// Combinational sign/zero extension of an assembled load word.
// Only the lanes belonging to the load type reach the result, so stale
// upper lanes in the raw word can never leak out.
module load_extend
  import dmem_byte_gather_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  ls,
  output logic [31:0] ext
);

  // Select the meaningful lanes and fill the rest with sign or zeros.
  always_comb begin
    ext = raw;
    case (ls)
      LS_H:    ext = {{16{raw[15]}}, raw[15:0]};
      LS_HU:   ext = {16'h0000, raw[15:0]};
      LS_B:    ext = {{24{raw[7]}}, raw[7:0]};
      LS_BU:   ext = {24'h000000, raw[7:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/dmem_byte_gather.sv
// Read-side byte gather: fetches 1, 2 or 4 lanes from a byte-wide data
// memory, lowest lane first, and presents an extended 32-bit load result.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no transfer; in_valid/in_byte ignored, out_data holds
//   ST_BUSY | fetching lane byte_idx; captures on in_valid, holds otherwise
module dmem_byte_gather
  import dmem_byte_gather_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  num,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        busy,
  output logic [1:0]  byte_idx,
  output logic        done,
  output logic [31:0] out_data
);

  gather_state_t state, state_nxt;
  logic [1:0]    count, count_nxt;
  logic [1:0]    last, last_nxt;
  logic [2:0]    ls_type, ls_type_nxt;
  logic [31:0]   acc, acc_nxt;
  logic          done_nxt;
  logic [31:0]   out_nxt;
  logic [31:0]   acc_merged;
  logic [31:0]   ext_result;

  // Accumulator as it would look with the incoming byte placed in lane[count].
  always_comb begin
    acc_merged = acc;
    case (count)
      2'd0:    acc_merged[7:0]   = in_byte;
      2'd1:    acc_merged[15:8]  = in_byte;
      2'd2:    acc_merged[23:16] = in_byte;
      default: acc_merged[31:24] = in_byte;
    endcase
  end

  // Extension sees the merged word so the final lane lands on the done edge.
  load_extend u_load_extend (
    .raw (acc_merged),
    .ls  (ls_type),
    .ext (ext_result)
  );

  // Next-state and datapath: start wins over capture, done is a one-cycle pulse.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    last_nxt    = last;
    ls_type_nxt = ls_type;
    acc_nxt     = acc;
    done_nxt    = 1'b0;
    out_nxt     = out_data;

    if (start) begin
      ls_type_nxt = num;
      last_nxt    = lane_last(num);
      count_nxt   = 2'd0;
      acc_nxt     = 32'h0000_0000;
      state_nxt   = ST_BUSY;
    end else begin
      case (state)
        ST_BUSY: begin
          if (in_valid) begin
            acc_nxt = acc_merged;
            if (count == last) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
              out_nxt   = ext_result;
            end else begin
              count_nxt = count + 2'd1;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register; reset abandons any transfer without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= 2'd0;
      last     <= 2'd0;
      ls_type  <= LS_W;
      acc      <= 32'h0000_0000;
      done     <= 1'b0;
      out_data <= 32'h0000_0000;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      last     <= last_nxt;
      ls_type  <= ls_type_nxt;
      acc      <= acc_nxt;
      done     <= done_nxt;
      out_data <= out_nxt;
    end
  end

  assign busy     = (state == ST_BUSY);
  assign byte_idx = count;

endmodule

// File: tb/tb_dmem_byte_gather.sv
// Self-checking bench for dmem_byte_gather: directed cases plus randomized
// loads with random stalls, compared against an arithmetic reference model.
module tb_dmem_byte_gather;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  num;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        busy;
  logic [1:0]  byte_idx;
  logic        done;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  dmem_byte_gather dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num      (num),
    .in_valid (in_valid),
    .in_byte  (in_byte),
    .busy     (busy),
    .byte_idx (byte_idx),
    .done     (done),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of bytes a load type fetches.
  function automatic int nbytes(input logic [2:0] ls);
    if (ls == 3'd3 || ls == 3'd4) return 1;
    if (ls == 3'd1 || ls == 3'd2) return 2;
    return 4;
  endfunction

  // Expected load result from the low bytes of w, computed arithmetically.
  function automatic logic [31:0] model(input logic [2:0] ls, input logic [31:0] w);
    int     n;
    longint raw;
    longint half;
    n    = nbytes(ls);
    raw  = longint'(w) % (longint'(1) << (8 * n));
    half = longint'(1) << (8 * n - 1);
    if ((ls == 3'd1 || ls == 3'd3) && raw >= half)
      raw = raw - 2 * half + (longint'(1) << 32);
    return raw[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One load: start, then lanes of w lowest first; in_valid is dropped for
  // stall_cycles cycles just before lane stall_lane.
  task automatic do_load(input string tag, input logic [2:0] ls, input logic [31:0] w,
                         input int stall_lane, input int stall_cycles);
    int          n;
    logic [31:0] exp;
    logic [31:0] wv;
    n   = nbytes(ls);
    exp = model(ls, w);
    wv  = w;
    @(negedge clk);
    start = 1'b1; num = ls; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == stall_lane) begin
        for (int s = 0; s < stall_cycles; s++) begin
          in_valid = 1'b0;
          in_byte  = 8'($urandom);
          check({tag, " stall idx"}, 32'(byte_idx), 32'(i));
          check({tag, " stall busy"}, 32'(busy), 32'd1);
          check({tag, " stall done"}, 32'(done), 32'd0);
          @(negedge clk);
        end
      end
      check({tag, " byte_idx"}, 32'(byte_idx), 32'(i));
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " early done"}, 32'(done), 32'd0);
      in_valid = 1'b1;
      in_byte  = wv[8*i +: 8];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy end"}, 32'(busy), 32'd0);
    check({tag, " out_data"}, out_data, exp);
    @(negedge clk);
    check({tag, " done clear"}, 32'(done), 32'd0);
    check({tag, " out hold"}, out_data, exp);
  endtask

  initial begin
    logic [31:0] prev_out;
    rst = 1'b1; start = 1'b0; num = 3'd0; in_valid = 1'b0; in_byte = 8'h00;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset out", out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    // Idle bytes are ignored.
    in_valid = 1'b1; in_byte = 8'hEE;
    @(negedge clk);
    in_valid = 1'b0;
    check("idle busy", 32'(busy), 32'd0);
    check("idle done", 32'(done), 32'd0);

    do_load("lw", 3'd0, 32'h12345678, -1, 0);
    check("lw value", out_data, 32'h12345678);
    do_load("lh", 3'd1, 32'h0000F234, -1, 0);
    check("lh value", out_data, 32'hFFFFF234);
    do_load("lhu", 3'd2, 32'h0000F234, -1, 0);
    check("lhu value", out_data, 32'h0000F234);
    do_load("lb", 3'd3, 32'h00000080, -1, 0);
    check("lb value", out_data, 32'hFFFFFF80);
    do_load("lbu", 3'd4, 32'h00000080, -1, 0);
    check("lbu value", out_data, 32'h00000080);
    do_load("lw stall", 3'd0, 32'h44332211, 2, 2);
    check("lw stall value", out_data, 32'h44332211);
    do_load("num111", 3'd7, 32'h04030201, -1, 0);
    check("num111 value", out_data, 32'h04030201);

    // Restart after one lw capture: no done for the abandoned load.
    @(negedge clk);
    start = 1'b1; num = 3'd0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_byte = 8'hAA;
    @(negedge clk);
    check("abort done0", 32'(done), 32'd0);
    start = 1'b1; num = 3'd4; in_byte = 8'h55;
    @(negedge clk);
    check("abort done1", 32'(done), 32'd0);
    check("abort out held", out_data, 32'h04030201);
    start = 1'b0; in_valid = 1'b1; in_byte = 8'h7F;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort new done", 32'(done), 32'd1);
    check("abort new out", out_data, 32'h0000007F);

    // Start on the edge where a lb final byte would have been captured.
    @(negedge clk);
    start = 1'b1; num = 3'd3;
    @(negedge clk);
    start = 1'b1; num = 3'd0; in_valid = 1'b1; in_byte = 8'h99;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    check("restart no done", 32'(done), 32'd0);
    check("restart out held", out_data, 32'h0000007F);
    check("restart busy", 32'(busy), 32'd1);
    check("restart idx", 32'(byte_idx), 32'd0);

    // Asynchronous reset part-way through a lw.
    @(negedge clk);
    start = 1'b1; num = 3'd0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_byte = 8'h01;
    @(negedge clk);
    in_byte = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst out", out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_load("lb after rst", 3'd3, 32'h000000FE, -1, 0);
    check("lb after rst value", out_data, 32'hFFFFFFFE);

    // Randomized loads with random stalls.
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  ls;
      logic [31:0] w;
      int          sl;
      int          sc;
      ls = 3'($urandom_range(0, 7));
      w  = $urandom;
      sl = $urandom_range(0, 4);
      sc = $urandom_range(0, 3);
      do_load("rand", ls, w, sl, sc);
    end

    // A start alone leaves out_data untouched.
    prev_out = out_data;
    @(negedge clk);
    start = 1'b1; num = 3'd0;
    @(negedge clk);
    start = 1'b0;
    check("start keeps out", out_data, prev_out);
    check("start no done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
